// File: rtl/adder_tree_acc.sv
// Streaming signed adder tree with packet accumulator and valid/ready handshakes.
// Define ADDER_TREE_SAT_EN for a saturating accumulator; otherwise it wraps.
module adder_tree_acc #(
    parameter int INPUT_NUM = 8,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = IN_WIDTH + $clog2(INPUT_NUM) + 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [INPUT_NUM*IN_WIDTH-1:0] din,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          dout,
    output logic                          out_sat
);

    localparam int STAGE_NUM  = $clog2(INPUT_NUM);
    localparam int TREE_WIDTH = IN_WIDTH + STAGE_NUM;
    localparam int PAD_NUM    = 1 << STAGE_NUM;
    localparam int NODE_NUM   = 2 * PAD_NUM - 1;

    // All tree stages live in one flat array: stage s starts at stage_off(s).
    function automatic int stage_off(input int s);
        return 2 * PAD_NUM - 2 * (PAD_NUM >> s);
    endfunction

    logic signed [TREE_WIDTH-1:0] lane0_d [PAD_NUM];
    logic signed [TREE_WIDTH-1:0] node_d  [NODE_NUM];
    logic signed [TREE_WIDTH-1:0] node_q  [NODE_NUM];
    logic [STAGE_NUM:0]           vld_q;
    logic [STAGE_NUM:0]           lst_q;
    logic signed [TREE_WIDTH-1:0] tree_sum;
    logic signed [ACC_WIDTH-1:0]  tree_ext;
    logic signed [ACC_WIDTH-1:0]  acc_q;
    logic signed [ACC_WIDTH-1:0]  acc_d;
    logic [ACC_WIDTH-1:0]         dout_q;
    logic                         out_valid_q;
    logic                         pipe_en;
    logic                         acc_fire;

    assign pipe_en  = !out_valid_q || out_ready;
    assign in_ready = pipe_en;
    assign acc_fire = pipe_en && vld_q[STAGE_NUM];

    for (genvar k = 0; k < PAD_NUM; k++) begin : g_lane
        if (k < INPUT_NUM) begin : g_op
            assign lane0_d[k] = TREE_WIDTH'(signed'(din[(k+1)*IN_WIDTH-1 -: IN_WIDTH]));
        end else begin : g_pad
            assign lane0_d[k] = '0;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        node_d = node_q;
        for (int k = 0; k < PAD_NUM; k++) begin
            node_d[k] = lane0_d[k];
        end
        for (int s = 1; s <= STAGE_NUM; s++) begin
            for (int j = 0; j < (PAD_NUM >> s); j++) begin
                node_d[stage_off(s) + j] = node_q[stage_off(s-1) + 2*j]
                                         + node_q[stage_off(s-1) + 2*j + 1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the tree array is reset too, so a packet cut by reset leaves no residue.
            node_q <= '{default: '0};
            vld_q  <= '0;
            lst_q  <= '0;
        end else if (pipe_en) begin
            // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
            node_q <= node_d;
            vld_q  <= {vld_q[STAGE_NUM-1:0], in_valid};
            lst_q  <= {lst_q[STAGE_NUM-1:0], in_last && in_valid};
        end
    end

    assign tree_sum = node_q[NODE_NUM-1];
    assign tree_ext = ACC_WIDTH'(tree_sum);

`ifdef ADDER_TREE_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] wide_sum;
    logic                      sat_hit;
    logic                      sat_flag_q;
    logic                      out_sat_q;

    always_comb begin
        wide_sum = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(tree_ext);
        sat_hit  = wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1];
        acc_d    = wide_sum[ACC_WIDTH-1:0];
        if (sat_hit) begin
            acc_d = wide_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_flag_q <= 1'b0;
            out_sat_q  <= 1'b0;
        end else if (acc_fire) begin
            if (lst_q[STAGE_NUM]) begin
                out_sat_q  <= sat_flag_q || sat_hit;
                sat_flag_q <= 1'b0;
            end else begin
                sat_flag_q <= sat_flag_q || sat_hit;
            end
        end
    end

    assign out_sat = out_sat_q;
`else
    assign acc_d   = acc_q + tree_ext;
    assign out_sat = 1'b0;
`endif

    // A last beat landing in the same cycle as an output handshake refreshes dout and keeps out_valid set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (acc_fire) begin
                if (lst_q[STAGE_NUM]) begin
                    dout_q      <= acc_d;
                    acc_q       <= '0;
                    out_valid_q <= 1'b1;
                end else begin
                    acc_q <= acc_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed self-checking bench for adder_tree_acc (INPUT_NUM=4 and INPUT_NUM=5 instances).
// Overflow expectations follow ADDER_TREE_SAT_EN.
module tb_adder_tree_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, out_ready;
    logic [31:0] din;
    logic        in_ready, out_valid, out_sat;
    logic [13:0] dout;

    logic        in_valid5, in_last5;
    logic [39:0] din5;
    logic        in_ready5, out_valid5, out_sat5;
    logic [14:0] dout5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adder_tree_acc #(.INPUT_NUM(4), .IN_WIDTH(8), .ACC_WIDTH(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_sat(out_sat)
    );

    adder_tree_acc #(.INPUT_NUM(5), .IN_WIDTH(8)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_last(in_last5), .din(din5),
        .out_valid(out_valid5), .out_ready(1'b1), .dout(dout5), .out_sat(out_sat5)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic send_beat(input logic [31:0] data, input logic last);
        in_valid = 1'b1;
        din      = data;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Runs n edges; reports how many cycles out_valid was high, the first edge it was seen and its payload.
    task automatic observe(input int n, output int pulses, output int first,
                           output logic signed [63:0] val, output logic sat);
        pulses = 0;
        first  = -1;
        val    = '0;
        sat    = 1'b0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    val   = $signed(dout);
                    sat   = out_sat;
                end
            end
        end
    endtask

    int                 pulses, first;
    logic signed [63:0] val;
    logic               sat;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        din       = '0;
        out_ready = 1'b1;
        in_valid5 = 1'b0;
        in_last5  = 1'b0;
        din5      = '0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", $signed(dout), 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Single one-beat packet: valid 3 edges after the accept edge, for one cycle.
        send_beat(pack4(1, 2, 3, 4), 1'b1);
        observe(6, pulses, first, val, sat);
        check("single_latency", first, 3);
        check("single_pulses", pulses, 1);
        check("single_dout", val, 10);
        check("single_sat", sat, 0);

        // Three beats with an input bubble: -512 + 508 + 5.
        send_beat(pack4(-128, -128, -128, -128), 1'b0);
        tick();
        send_beat(pack4(127, 127, 127, 127), 1'b0);
        send_beat(pack4(1, -1, 5, 0), 1'b1);
        observe(6, pulses, first, val, sat);
        check("bubble_latency", first, 3);
        check("bubble_pulses", pulses, 1);
        check("bubble_dout", val, 1);

        // Backpressure: A=4 stalls at the output while B=8 waits in the tree.
        out_ready = 1'b0;
        send_beat(pack4(1, 1, 1, 1), 1'b1);
        check("bp_b_accept_ready", in_ready, 1);
        send_beat(pack4(2, 2, 2, 2), 1'b1);
        tick();
        tick();
        check("bp_a_valid", out_valid, 1);
        check("bp_a_dout", $signed(dout), 4);
        check("bp_stall_ready", in_ready, 0);
        tick();
        tick();
        tick();
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_dout", $signed(dout), 4);
        check("bp_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        check("bp_b_valid", out_valid, 1);
        check("bp_b_dout", $signed(dout), 8);
        tick();
        check("bp_drained", out_valid, 0);

        // Non-power-of-two lane count: padded to 8 lanes, one extra tree stage.
        in_valid5 = 1'b1;
        in_last5  = 1'b1;
        din5      = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        tick();
        in_valid5 = 1'b0;
        in_last5  = 1'b0;
        first     = -1;
        val       = '0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (out_valid5 === 1'b1 && first < 0) begin
                first = i;
                val   = $signed(dout5);
            end
        end
        check("npot_latency", first, 4);
        check("npot_dout", val, 15);

        // Overflow: 17 beats of 508 each overrun a 14-bit accumulator.
        in_valid = 1'b1;
        din      = pack4(127, 127, 127, 127);
        for (int i = 0; i < 17; i++) begin
            in_last = (i == 16);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        observe(6, pulses, first, val, sat);
        check("ovf_latency", first, 3);
`ifdef ADDER_TREE_SAT_EN
        check("ovf_dout", val, 8191);
        check("ovf_sat", sat, 1);
`else
        check("ovf_dout", val, -7748);
        check("ovf_sat", sat, 0);
`endif

        // Reset in the middle of a packet discards it completely.
        send_beat(pack4(9, 9, 9, 9), 1'b0);
        send_beat(pack4(9, 9, 9, 9), 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_dout", $signed(dout), 0);
        observe(5, pulses, first, val, sat);
        check("rstmid_no_output", pulses, 0);
        send_beat(pack4(1, 1, 1, 1), 1'b1);
        observe(6, pulses, first, val, sat);
        check("rstmid_pulses", pulses, 1);
        check("rstmid_dout_after", val, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
